// File: rtl/tile_match_ctrl_if.sv
// Selection handshake and RAM port bundle for tile_match_ctrl.
// slave  : the controller's view (accepts selections, drives the RAM port).
// master : the environment's view (cursor logic plus the tile RAM).
interface tile_match_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              sel_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_ready;
  logic              sel_err;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output sel_valid, sel_addr, ram_rdata,
    input  sel_ready, sel_err, ram_addr, ram_we, ram_wdata
  );

  modport slave (
    input  sel_valid, sel_addr, ram_rdata,
    output sel_ready, sel_err, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/tile_match_ctrl.sv
// tile_match_ctrl: memory-game controller for one port of the tile colour RAM.
// Reads two selected tiles, clears them on a colour match, otherwise holds both
// revealed for HOLD_CYCLES. Tracks remaining pairs and flags game completion.
// Optional: define TILE_MATCH_MOVES_EN to enable the saturating attempt counter
// on `moves`; otherwise `moves` is tied to zero.
module tile_match_ctrl #(
  parameter int              ADDR_W      = 4,
  parameter int              DATA_W      = 8,
  parameter logic [DATA_W-1:0] CLEARED   = '0,
  parameter int              PAIRS       = 8,
  parameter int              HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              resetn,
  tile_match_ctrl_if.slave  bus,
  output logic              reveal_a_valid,
  output logic [ADDR_W-1:0] reveal_a_addr,
  output logic              reveal_b_valid,
  output logic [ADDR_W-1:0] reveal_b_addr,
  output logic              match_pulse,
  output logic              miss_pulse,
  output logic [3:0]        pairs_left,
  output logic              game_done,
  output logic [7:0]        moves
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, RD_A, CAP_A, WAIT_B, RD_B, CAP_B, CLR_A, CLR_B, HOLD, DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [DATA_W-1:0] color_a_q, color_a_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              sel_err_q, sel_err_d;
  logic              reveal_a_valid_q, reveal_a_valid_d;
  logic [ADDR_W-1:0] reveal_a_addr_q, reveal_a_addr_d;
  logic              reveal_b_valid_q, reveal_b_valid_d;
  logic [ADDR_W-1:0] reveal_b_addr_q, reveal_b_addr_d;
  logic              match_pulse_q, match_pulse_d;
  logic              miss_pulse_q, miss_pulse_d;
  logic [3:0]        pairs_left_q, pairs_left_d;
  logic              game_done_q, game_done_d;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic              sel_ready;

  // Next-state and registered-output logic; pulses and write enable default low.
  always_comb begin
    state_d          = state_q;
    addr_a_d         = addr_a_q;
    addr_b_d         = addr_b_q;
    color_a_d        = color_a_q;
    ram_addr_d       = ram_addr_q;
    ram_we_d         = 1'b0;
    ram_wdata_d      = ram_wdata_q;
    sel_err_d        = 1'b0;
    reveal_a_valid_d = reveal_a_valid_q;
    reveal_a_addr_d  = reveal_a_addr_q;
    reveal_b_valid_d = reveal_b_valid_q;
    reveal_b_addr_d  = reveal_b_addr_q;
    match_pulse_d    = 1'b0;
    miss_pulse_d     = 1'b0;
    pairs_left_d     = pairs_left_q;
    game_done_d      = game_done_q;
    hold_cnt_d       = hold_cnt_q;
    sel_ready        = 1'b0;
    unique case (state_q)
      IDLE: begin
        sel_ready = 1'b1;
        if (bus.sel_valid) begin
          addr_a_d   = bus.sel_addr;
          ram_addr_d = bus.sel_addr;
          state_d    = RD_A;
        end
      end
      RD_A: state_d = CAP_A;
      CAP_A: begin
        if (bus.ram_rdata == CLEARED) begin
          sel_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          color_a_d        = bus.ram_rdata;
          reveal_a_valid_d = 1'b1;
          reveal_a_addr_d  = addr_a_q;
          state_d          = WAIT_B;
        end
      end
      WAIT_B: begin
        sel_ready = 1'b1;
        if (bus.sel_valid) begin
          if (bus.sel_addr == addr_a_q) begin
            sel_err_d = 1'b1;
          end else begin
            addr_b_d   = bus.sel_addr;
            ram_addr_d = bus.sel_addr;
            state_d    = RD_B;
          end
        end
      end
      RD_B: state_d = CAP_B;
      CAP_B: begin
        if (bus.ram_rdata == CLEARED) begin
          sel_err_d = 1'b1;
          state_d   = WAIT_B;
        end else if (bus.ram_rdata == color_a_q) begin
          // Outputs are registered, so the first clear write is set up here.
          ram_we_d      = 1'b1;
          ram_addr_d    = addr_a_q;
          ram_wdata_d   = CLEARED;
          match_pulse_d = 1'b1;
          state_d       = CLR_A;
        end else begin
          miss_pulse_d     = 1'b1;
          reveal_b_valid_d = 1'b1;
          reveal_b_addr_d  = addr_b_q;
          hold_cnt_d       = HOLD_LOAD;
          state_d          = HOLD;
        end
      end
      CLR_A: begin
        ram_we_d    = 1'b1;
        ram_addr_d  = addr_b_q;
        ram_wdata_d = CLEARED;
        state_d     = CLR_B;
      end
      CLR_B: begin
        pairs_left_d     = pairs_left_q - 4'd1;
        reveal_a_valid_d = 1'b0;
        reveal_b_valid_d = 1'b0;
        if (pairs_left_q == 4'd1) begin
          game_done_d = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (hold_cnt_q == '0) begin
          reveal_a_valid_d = 1'b0;
          reveal_b_valid_d = 1'b0;
          state_d          = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - CNT_W'(1);
        end
      end
      DONE: game_done_d = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any in-progress operation.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= IDLE;
      addr_a_q         <= '0;
      addr_b_q         <= '0;
      color_a_q        <= '0;
      ram_addr_q       <= '0;
      ram_we_q         <= 1'b0;
      ram_wdata_q      <= '0;
      sel_err_q        <= 1'b0;
      reveal_a_valid_q <= 1'b0;
      reveal_a_addr_q  <= '0;
      reveal_b_valid_q <= 1'b0;
      reveal_b_addr_q  <= '0;
      match_pulse_q    <= 1'b0;
      miss_pulse_q     <= 1'b0;
      pairs_left_q     <= 4'(PAIRS);
      game_done_q      <= 1'b0;
      hold_cnt_q       <= '0;
    end else begin
      state_q          <= state_d;
      addr_a_q         <= addr_a_d;
      addr_b_q         <= addr_b_d;
      color_a_q        <= color_a_d;
      ram_addr_q       <= ram_addr_d;
      ram_we_q         <= ram_we_d;
      ram_wdata_q      <= ram_wdata_d;
      sel_err_q        <= sel_err_d;
      reveal_a_valid_q <= reveal_a_valid_d;
      reveal_a_addr_q  <= reveal_a_addr_d;
      reveal_b_valid_q <= reveal_b_valid_d;
      reveal_b_addr_q  <= reveal_b_addr_d;
      match_pulse_q    <= match_pulse_d;
      miss_pulse_q     <= miss_pulse_d;
      pairs_left_q     <= pairs_left_d;
      game_done_q      <= game_done_d;
      hold_cnt_q       <= hold_cnt_d;
    end
  end

`ifdef TILE_MATCH_MOVES_EN
  logic [7:0] moves_q, moves_d;

  // Saturating attempt counter, stepped alongside each result strobe.
  always_comb begin
    moves_d = moves_q;
    if ((match_pulse_d || miss_pulse_d) && (moves_q != 8'hFF)) begin
      moves_d = moves_q + 8'd1;
    end
  end

  // Attempt counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) moves_q <= '0;
    else         moves_q <= moves_d;
  end

  assign moves = moves_q;
`else
  assign moves = '0;
`endif

  assign bus.sel_ready   = sel_ready;
  assign bus.sel_err     = sel_err_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_wdata   = ram_wdata_q;
  assign reveal_a_valid  = reveal_a_valid_q;
  assign reveal_a_addr   = reveal_a_addr_q;
  assign reveal_b_valid  = reveal_b_valid_q;
  assign reveal_b_addr   = reveal_b_addr_q;
  assign match_pulse     = match_pulse_q;
  assign miss_pulse      = miss_pulse_q;
  assign pairs_left      = pairs_left_q;
  assign game_done       = game_done_q;

endmodule

// File: tb/tb_tile_match_ctrl.sv
// Self-checking bench for tile_match_ctrl: a 1-cycle registered tile RAM plus a
// game-rule reference model (tile colours, pairs remaining, attempts).
module tb_tile_match_ctrl;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       reveal_a_valid, reveal_b_valid, match_pulse, miss_pulse, game_done;
  logic [3:0] reveal_a_addr, reveal_b_addr, pairs_left;
  logic [7:0] moves;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;

  logic [7:0] ram   [16];
  logic [7:0] m_mem [16];
  int         m_pairs;
  int         m_moves;
  logic [3:0] m_a;

  always #5 clk = ~clk;

  tile_match_ctrl_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  tile_match_ctrl #(
    .ADDR_W(4), .DATA_W(8), .CLEARED(8'h00), .PAIRS(8), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus),
    .reveal_a_valid(reveal_a_valid), .reveal_a_addr(reveal_a_addr),
    .reveal_b_valid(reveal_b_valid), .reveal_b_addr(reveal_b_addr),
    .match_pulse(match_pulse), .miss_pulse(miss_pulse),
    .pairs_left(pairs_left), .game_done(game_done), .moves(moves)
  );

  function automatic logic [7:0] layout(input int i);
    case (i)
      0: return 8'h3C;  1: return 8'hC8;  2: return 8'hE0;  3: return 8'hE0;
      4: return 8'hD0;  5: return 8'h8C;  6: return 8'hF0;  7: return 8'h0C;
      8: return 8'hC8;  9: return 8'hD0; 10: return 8'hF0; 11: return 8'h70;
     12: return 8'h8C; 13: return 8'h70; 14: return 8'h3C; default: return 8'h0C;
    endcase
  endfunction

  function automatic logic [7:0] exp_moves();
`ifdef TILE_MATCH_MOVES_EN
    return 8'(m_moves);
`else
    return 8'd0;
`endif
  endfunction

  // Tile RAM: registered read, write port, layout restored by its own reset.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 16; i++) ram[i] <= layout(i);
      bus.ram_rdata <= 8'h00;
    end else begin
      if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= ram[bus.ram_addr];
    end
  end

  always @(posedge clk) if (resetn && bus.ram_we) wr_count <= wr_count + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic model_init();
    for (int i = 0; i < 16; i++) m_mem[i] = layout(i);
    m_pairs = 8;
    m_moves = 0;
  endtask

  // Waits (bounded) for sel_ready, then presents one selection for one edge.
  task automatic do_sel(input logic [3:0] a);
    int w = 0;
    @(negedge clk);
    while (bus.sel_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (w >= 50) begin
      n_fail++;
      $display("FAIL sel_ready_timeout: sel_ready=%b after 50 cycles, required 1", bus.sel_ready);
    end
    bus.sel_valid = 1'b1;
    bus.sel_addr  = a;
    @(negedge clk);
    bus.sel_valid = 1'b0;
  endtask

  task automatic first_sel(input logic [3:0] a, output bit acc);
    bit rej = (m_mem[a] == 8'h00);
    do_sel(a);
    n_checks++;
    if (bus.sel_ready !== 1'b0) begin
      n_fail++; $display("FAIL first_busy: sel_ready=%b required 0", bus.sel_ready);
    end
    @(negedge clk); @(negedge clk);
    if (rej) begin
      n_checks++;
      if ({bus.sel_err, bus.sel_ready, reveal_a_valid} !== 3'b110) begin
        n_fail++;
        $display("FAIL first_reject: err/ready/reveal_a=%b required 110",
                 {bus.sel_err, bus.sel_ready, reveal_a_valid});
      end
      @(negedge clk);
      n_checks++;
      if (bus.sel_err !== 1'b0) begin
        n_fail++; $display("FAIL err_one_cycle: sel_err=%b required 0", bus.sel_err);
      end
      acc = 1'b0;
    end else begin
      n_checks++;
      if ({bus.sel_err, bus.sel_ready, reveal_a_valid, reveal_a_addr} !== {3'b011, a}) begin
        n_fail++;
        $display("FAIL first_accept: err/ready/reveal_a/addr=%b required %b",
                 {bus.sel_err, bus.sel_ready, reveal_a_valid, reveal_a_addr}, {3'b011, a});
      end
      m_a = a;
      acc = 1'b1;
    end
  endtask

  task automatic second_sel(input logic [3:0] b, output bit res);
    int wr0 = wr_count;
    res = 1'b0;
    do_sel(b);
    if (b == m_a) begin
      n_checks++;
      if ({bus.sel_err, bus.sel_ready, reveal_a_valid} !== 3'b111) begin
        n_fail++;
        $display("FAIL same_tile: err/ready/reveal_a=%b required 111",
                 {bus.sel_err, bus.sel_ready, reveal_a_valid});
      end
      return;
    end
    n_checks++;
    if ({bus.sel_err, bus.sel_ready} !== 2'b00) begin
      n_fail++; $display("FAIL rd_b: err/ready=%b required 00", {bus.sel_err, bus.sel_ready});
    end
    @(negedge clk); @(negedge clk);
    if (m_mem[b] == 8'h00) begin
      n_checks++;
      if ({bus.sel_err, bus.sel_ready, match_pulse, miss_pulse, reveal_a_valid} !== 5'b11001) begin
        n_fail++;
        $display("FAIL second_cleared: err/ready/match/miss/reveal_a=%b required 11001",
                 {bus.sel_err, bus.sel_ready, match_pulse, miss_pulse, reveal_a_valid});
      end
    end else if (m_mem[b] == m_mem[m_a]) begin
      n_checks++;
      if ({match_pulse, miss_pulse, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.sel_ready}
          !== {3'b101, m_a, 8'h00, 1'b0}) begin
        n_fail++;
        $display("FAIL clr_a: match/miss/we/addr/wdata/ready=%b required %b",
                 {match_pulse, miss_pulse, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.sel_ready},
                 {3'b101, m_a, 8'h00, 1'b0});
      end
      m_mem[m_a] = 8'h00;
      m_mem[b]   = 8'h00;
      m_pairs--;
      if (m_moves < 255) m_moves++;
      @(negedge clk);
      n_checks++;
      if ({match_pulse, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.sel_ready}
          !== {2'b01, b, 8'h00, 1'b0}) begin
        n_fail++;
        $display("FAIL clr_b: match/we/addr/wdata/ready=%b required %b",
                 {match_pulse, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.sel_ready},
                 {2'b01, b, 8'h00, 1'b0});
      end
      @(negedge clk);
      n_checks++;
      if ({bus.ram_we, reveal_a_valid, reveal_b_valid, pairs_left, game_done, bus.sel_ready}
          !== {3'b000, 4'(m_pairs), m_pairs == 0, m_pairs != 0}) begin
        n_fail++;
        $display("FAIL match_done: we/rev_a/rev_b/pairs/done/ready=%b required %b",
                 {bus.ram_we, reveal_a_valid, reveal_b_valid, pairs_left, game_done, bus.sel_ready},
                 {3'b000, 4'(m_pairs), m_pairs == 0, m_pairs != 0});
      end
      n_checks++;
      if ({ram[m_a], ram[b]} !== 16'h0000 || (wr_count - wr0) != 2) begin
        n_fail++;
        $display("FAIL ram_cleared: ram[a]=%h ram[b]=%h writes=%0d required 00 00 2",
                 ram[m_a], ram[b], wr_count - wr0);
      end
      n_checks++;
      if (moves !== exp_moves()) begin
        n_fail++; $display("FAIL moves_match: moves=%0d required %0d", moves, exp_moves());
      end
      res = 1'b1;
    end else begin
      int nb = 0;
      int nm = 0;
      int rdy = -1;
      n_checks++;
      if ({match_pulse, miss_pulse, reveal_a_valid, reveal_a_addr, reveal_b_valid, reveal_b_addr}
          !== {3'b011, m_a, 1'b1, b}) begin
        n_fail++;
        $display("FAIL miss_entry: match/miss/ra/ra_addr/rb/rb_addr=%b required %b",
                 {match_pulse, miss_pulse, reveal_a_valid, reveal_a_addr, reveal_b_valid, reveal_b_addr},
                 {3'b011, m_a, 1'b1, b});
      end
      if (m_moves < 255) m_moves++;
      for (int c = 3; c < 3 + HOLD + 3; c++) begin
        if (reveal_b_valid === 1'b1) nb++;
        if (miss_pulse === 1'b1) nm++;
        if (rdy < 0 && bus.sel_ready === 1'b1) rdy = c;
        @(negedge clk);
      end
      n_checks++;
      if (nb != HOLD || nm != 1 || rdy != 3 + HOLD) begin
        n_fail++;
        $display("FAIL hold_timing: reveal_b=%0d miss=%0d ready_at=%0d required %0d 1 %0d",
                 nb, nm, rdy, HOLD, 3 + HOLD);
      end
      n_checks++;
      if (wr_count != wr0 || reveal_a_valid !== 1'b0 || moves !== exp_moves()) begin
        n_fail++;
        $display("FAIL miss_after: writes=%0d rev_a=%b moves=%0d required 0 0 %0d",
                 wr_count - wr0, reveal_a_valid, moves, exp_moves());
      end
      res = 1'b1;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.sel_valid = 1'b0;
    bus.sel_addr  = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.ram_addr, bus.ram_we, bus.ram_wdata, reveal_a_valid, reveal_a_addr, reveal_b_valid,
         reveal_b_addr, bus.sel_err, match_pulse, miss_pulse, game_done} !== 27'd0) begin
      n_fail++; $display("FAIL reset_outputs: some output nonzero, required all 0");
    end
    n_checks++;
    if ({pairs_left, moves, bus.sel_ready} !== {4'd8, 8'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_counters: pairs=%0d moves=%0d ready=%b required 8 0 1",
               pairs_left, moves, bus.sel_ready);
    end
    resetn = 1'b1;
    model_init();
    @(negedge clk);
  endtask

  task automatic test_match();
    bit acc, res;
    first_sel(4'd2, acc);
    second_sel(4'd3, res);
  endtask

  task automatic test_mismatch();
    bit acc, res;
    first_sel(4'd0, acc);
    second_sel(4'd1, res);
  endtask

  task automatic test_errors();
    bit acc, res;
    first_sel(4'd2, acc);
    first_sel(4'd5, acc);
    second_sel(4'd5, res);
    second_sel(4'd3, res);
    second_sel(4'd12, res);
  endtask

  task automatic test_clear_all();
    for (int t = 0; t < 300 && m_pairs > 0; t++) begin
      logic [3:0] a, b, partner;
      bit acc, res;
      int cand[$];
      for (int i = 0; i < 16; i++) if (m_mem[i] != 8'h00) cand.push_back(i);
      if ($urandom_range(0, 3) == 0) a = 4'($urandom_range(0, 15));
      else a = 4'(cand[$urandom_range(0, cand.size() - 1)]);
      first_sel(a, acc);
      if (!acc) continue;
      partner = a;
      for (int j = 0; j < 16; j++) if (j != int'(a) && m_mem[j] == m_mem[a]) partner = 4'(j);
      res = 1'b0;
      for (int k = 0; k < 6 && !res; k++) begin
        case ($urandom_range(0, 3))
          0: b = a;
          1: b = 4'($urandom_range(0, 15));
          default: b = partner;
        endcase
        second_sel(b, res);
      end
      if (!res) second_sel(partner, res);
    end
  endtask

  task automatic test_done();
    int wr0 = wr_count;
    n_checks++;
    if ({pairs_left, game_done, bus.sel_ready} !== {4'd0, 2'b10}) begin
      n_fail++;
      $display("FAIL game_done: pairs=%0d done=%b ready=%b required 0 1 0",
               pairs_left, game_done, bus.sel_ready);
    end
    for (int i = 0; i < 6; i++) begin
      bus.sel_valid = 1'b1;
      bus.sel_addr  = 4'($urandom_range(0, 15));
      @(negedge clk);
      n_checks++;
      if ({bus.sel_err, bus.sel_ready, game_done, bus.ram_we, match_pulse, miss_pulse} !== 6'b001000) begin
        n_fail++;
        $display("FAIL done_ignores: err/ready/done/we/match/miss=%b required 001000",
                 {bus.sel_err, bus.sel_ready, game_done, bus.ram_we, match_pulse, miss_pulse});
      end
    end
    bus.sel_valid = 1'b0;
    n_checks++;
    if (wr_count != wr0 || pairs_left !== 4'd0) begin
      n_fail++;
      $display("FAIL done_stable: writes=%0d pairs=%0d required 0 0", wr_count - wr0, pairs_left);
    end
  endtask

  task automatic test_reset_mid();
    bit acc, res;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    model_init();
    do_sel(4'd2);
    @(negedge clk); @(negedge clk);
    do_sel(4'd3);
    @(negedge clk); @(negedge clk);
    n_checks++;
    if ({match_pulse, bus.ram_we} !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_clr_a: match/we=%b required 11", {match_pulse, bus.ram_we});
    end
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({bus.ram_addr, bus.ram_we, bus.ram_wdata, reveal_a_valid, reveal_a_addr, reveal_b_valid,
         reveal_b_addr, bus.sel_err, match_pulse, miss_pulse, game_done} !== 27'd0) begin
      n_fail++; $display("FAIL async_reset_outputs: some output nonzero, required all 0");
    end
    n_checks++;
    if ({pairs_left, moves, bus.sel_ready} !== {4'd8, 8'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL async_reset_counters: pairs=%0d moves=%0d ready=%b required 8 0 1",
               pairs_left, moves, bus.sel_ready);
    end
    @(negedge clk);
    resetn = 1'b1;
    first_sel(4'd2, acc);
    second_sel(4'd3, res);
  endtask

  initial begin
    bus.sel_valid = 1'b0;
    bus.sel_addr  = '0;
    test_reset();
    test_match();
    test_mismatch();
    test_errors();
    test_clear_all();
    test_done();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tile_match_ctrl.md
# tile_match_ctrl

Game-logic initiator for one port of the 16-entry tile colour RAM. It accepts two player tile selections, reads both colours through the RAM port, and compares them. On a match it writes the cleared colour back to both tiles; on a mismatch it holds both tiles revealed for a fixed time. It tracks remaining pairs and flags game completion, and sits between the input/cursor logic and the RAM, alongside the VGA drawer, which uses the other RAM ports.

## Interface
- ADDR_W, 4, tile address width (16 tiles)
- DATA_W, 8, tile colour width
- CLEARED, 8'h00, colour written to matched tiles; a read of this value means the tile is already gone
- PAIRS, 8, number of pairs at game start
- HOLD_CYCLES, 4, mismatch reveal duration in cycles (≥1; set large for on-board use)
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- sel_valid  in  1  player selection strobe
- sel_addr  in  ADDR_W  selected tile
- sel_ready  out  1  selection can be accepted this cycle
- sel_err  out  1  one-cycle pulse: last selection rejected
- ram_addr  out  ADDR_W  RAM port address, registered
- ram_we  out  1  RAM port write enable, registered
- ram_wdata  out  DATA_W  RAM port write data, registered
- ram_rdata  in  DATA_W  RAM port read data (1-cycle registered RAM)
- reveal_a_valid / reveal_a_addr  out  1 / ADDR_W  first tile shown face-up
- reveal_b_valid / reveal_b_addr  out  1 / ADDR_W  second tile shown face-up
- match_pulse, miss_pulse  out  1  one-cycle result strobes
- pairs_left  out  4  remaining pairs
- game_done  out  1  high once pairs_left reaches 0
- moves  out  8  attempt counter (see Configuration)

## Operation
- States: IDLE, RD_A, CAP_A, WAIT_B, RD_B, CAP_B, CLR_A, CLR_B, HOLD, DONE.
- sel_ready = 1 only in IDLE and WAIT_B. A handshake occurs when sel_valid && sel_ready at a rising edge.
- IDLE accept: latch the address into addr_a, set ram_addr = addr_a, go to RD_A.
- RD_A: the RAM samples the address. Go to CAP_A.
- CAP_A: ram_rdata is valid. If it equals CLEARED, pulse sel_err and go to IDLE. Otherwise latch color_a, set reveal_a_valid, and go to WAIT_B.
- WAIT_B accept:
  - If sel_addr == addr_a, pulse sel_err and stay in WAIT_B.
  - Otherwise latch addr_b and go to RD_B.
- CAP_B:
  - If rdata == CLEARED, pulse sel_err and go to WAIT_B.
  - If rdata == color_a, go to CLR_A.
  - Otherwise go to HOLD.
- CLR_A: ram_we = 1, ram_addr = addr_a, ram_wdata = CLEARED. match_pulse is high this cycle. Go to CLR_B.
- CLR_B: ram_we = 1, ram_addr = addr_b. pairs_left is decremented at the end of this state. Clear both reveal flags. Go to DONE if the new pairs_left is 0, else IDLE.
- HOLD:
  - reveal_b_valid = 1; miss_pulse is high in the first HOLD cycle only.
  - The hold counter loads HOLD_CYCLES-1 on entry and counts down. Exit at 0 to IDLE, clearing both reveal flags.
- DONE: terminal state. sel_ready = 0, game_done = 1, until reset.
- sel_valid outside sel_ready is ignored, with no error.
- ram_we is high only in CLR_A and CLR_B.

## Timing
- Reset (async assert, sync release):
  - State IDLE; pairs_left = PAIRS; moves = 0.
  - All other outputs are 0: ram_addr, ram_we, ram_wdata, reveal flags and addresses, pulses, game_done.
- The read latency assumed is exactly one cycle: ram_rdata is sampled in the cycle after ram_addr is presented.
- Second-selection handshake to match_pulse: 3 cycles (RD_B, CAP_B, CLR_A).
- Second-selection handshake to miss_pulse: 3 cycles.
- sel_err is asserted in the cycle immediately following the rejecting edge.
- Handshake to the next sel_ready:
  - Match path: 5 cycles.
  - Mismatch path: 3 + HOLD_CYCLES cycles.
- Reset mid-operation aborts immediately. Any in-progress clear is abandoned; the RAM's own reset restores the layout.

## Configuration
- TILE_MATCH_MOVES_EN defined: moves increments by 1 on every match_pulse or miss_pulse and saturates at 255.
- Not defined: the counter logic is absent and moves is tied to 0.

## Test plan
- Bench RAM model (1-cycle read) preloaded: 0=3C, 1=C8, 2=E0, 3=E0, 4=D0, 5=8C, 6=F0, 7=0C, 8=C8, 9=D0, 10=F0, 11=70, 12=8C, 13=70, 14=3C, 15=0C.
- Select 2 then 3:
  - match_pulse exactly 3 cycles after the second handshake.
  - RAM[2] = RAM[3] = 00.
  - pairs_left 8→7; moves = 1 with the macro.
- Select 0 then 1, HOLD_CYCLES = 4:
  - miss_pulse once; reveal_b_valid high for 4 cycles.
  - No RAM writes; sel_ready returns 7 cycles after the handshake.
- After clearing 2/3:
  - Selecting 2 as first → sel_err, back to IDLE.
  - Select 5, then 5 again → sel_err, still in WAIT_B.
  - Then 3 → sel_err; then 12 → match.
- Clear all 8 pairs: pairs_left = 0, game_done = 1, sel_ready = 0; further sel_valid has no effect.
- Assert resetn low during CLR_A: all outputs return to reset values asynchronously, and pairs_left = 8.
